// File: rtl/mem_slice_responder.sv
// MEM-slice responder: executes dispatcher read bursts / single-vector writes
// against a local vector SRAM and streams read data onto an SRF write port.
module mem_slice_responder #(
  parameter int ADDR_WIDTH          = 10,
  parameter int NUM_VECTORS         = 5,
  parameter int NUM_STREAM_ID       = 5,
  parameter int MIN_VEC_LENGTH      = 16,
  parameter int NUM_TILES_PER_SLICE = 20
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  mem_read_enable,
  input  logic                                                  mem_write_enable,
  input  logic [ADDR_WIDTH-1:0]                                 mem_address,
  input  logic [NUM_VECTORS-1:0]                                vector_length,
  input  logic [NUM_STREAM_ID-1:0]                              stream_dest,
  input  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]    write_data,
  output logic                                                  srf_wr_en,
  output logic [NUM_STREAM_ID-1:0]                              srf_wr_stream,
  output logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0]    srf_wr_data,
  output logic                                                  busy,
  output logic                                                  op_done,
  output logic                                                  cmd_dropped,
  output logic                                                  cmd_conflict
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, READ} state_e;

  state_e                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            ptr_q, ptr_d;
  logic [NUM_VECTORS-1:0]           cnt_q, cnt_d;
  logic [NUM_STREAM_ID-1:0]         strm_q, strm_d;
  logic [NUM_STREAM_ID-1:0]         out_strm_q;
  logic                             en_q, en_d;
  logic                             done_q, done_d;
  logic                             drop_q, drop_d;
  logic                             conf_q, conf_d;
  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] data_q;
  logic [NUM_TILES_PER_SLICE-1:0][MIN_VEC_LENGTH-1:0] mem [DEPTH];

  logic issue, last, ready, any_cmd, both_cmd, rd_go, wr_go;

  // The final issue edge of a burst already accepts a new command, so
  // consecutive bursts run without a bubble.
  always_comb begin
    issue    = (state_q == READ);
    last     = issue && (cnt_q == NUM_VECTORS'(1));
    ready    = !issue || last;
    any_cmd  = mem_read_enable || mem_write_enable;
    both_cmd = mem_read_enable && mem_write_enable;
    rd_go    = mem_read_enable && !mem_write_enable && ready;
    wr_go    = mem_write_enable && !mem_read_enable && ready && rst_n;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    strm_d  = strm_q;
    en_d    = issue;
    done_d  = last || wr_go;
    drop_d  = drop_q || (any_cmd && !ready);
    conf_d  = conf_q || both_cmd;
    if (issue) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      cnt_d = cnt_q - NUM_VECTORS'(1);
      if (last) state_d = IDLE;
    end
    if (rd_go) begin
      state_d = READ;
      ptr_d   = mem_address;
      cnt_d   = (vector_length == '0) ? NUM_VECTORS'(1) : vector_length;
      strm_d  = stream_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      strm_q     <= '0;
      out_strm_q <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      conf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      strm_q  <= strm_d;
      en_q    <= en_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      conf_q  <= conf_d;
      // Stream travels with its beat so a back-to-back burst cannot retag it.
      if (issue) out_strm_q <= strm_q;
    end
  end

  // SRAM array is never reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_go) mem[mem_address] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     data_q <= '0;
    else if (issue) data_q <= mem[ptr_q];
  end

  assign srf_wr_en     = en_q;
  assign srf_wr_stream = out_strm_q;
  assign srf_wr_data   = data_q;
  assign busy          = issue;
  assign op_done       = done_q;
  assign cmd_dropped   = drop_q;
  assign cmd_conflict  = conf_q;

endmodule

// File: tb/tb_mem_slice_responder.sv
// Randomized bench for mem_slice_responder against a beat-queue reference model.
module tb_mem_slice_responder;
  localparam int AW = 10, NV = 5, NS = 5, W = 16, T = 20;
  localparam int VB = W * T;

  logic clk, rst_n, rd, wr, en, bsy, done, drop, conf;
  logic [AW-1:0] addr;
  logic [NV-1:0] len;
  logic [NS-1:0] sdst, ostrm;
  logic [T-1:0][W-1:0] wdata, odata;

  mem_slice_responder #(.ADDR_WIDTH(AW), .NUM_VECTORS(NV), .NUM_STREAM_ID(NS),
    .MIN_VEC_LENGTH(W), .NUM_TILES_PER_SLICE(T)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_enable(rd), .mem_write_enable(wr),
    .mem_address(addr), .vector_length(len), .stream_dest(sdst), .write_data(wdata),
    .srf_wr_en(en), .srf_wr_stream(ostrm), .srf_wr_data(odata), .busy(bsy),
    .op_done(done), .cmd_dropped(drop), .cmd_conflict(conf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a read enqueues its N beats (data snapshotted at accept,
  // since no write can land before those beats are read); one beat leaves per edge.
  typedef struct { logic [VB-1:0] d; logic [NS-1:0] s; bit last; } beat_t;
  beat_t bq[$];
  logic [VB-1:0] mmem [1024];
  bit mknown [1024];
  bit e_en, e_busy, e_done, e_drop, e_conf, e_ds, e_known;
  logic [VB-1:0] e_data;
  logic [NS-1:0] e_strm;

  task automatic model(input bit r, input bit w, input int a, input int n_in,
                       input logic [NS-1:0] s, input logic [VB-1:0] wd, input bit rn);
    bit rdy;
    int n;
    beat_t b;
    if (!rn) begin
      bq.delete();
      {e_en, e_busy, e_done, e_drop, e_conf} = '0;
      e_ds = 1; e_known = 1; e_data = '0; e_strm = '0;
      return;
    end
    rdy = (bq.size() <= 1);
    e_done = 0; e_ds = 0; e_en = 0;
    if (bq.size() > 0) begin
      b = bq.pop_front();
      e_en = 1; e_ds = 1; e_data = b.d; e_strm = b.s; e_done = b.last;
      e_known = (b.d !== 'x);
    end
    if (r && !w && rdy) begin
      n = (n_in == 0) ? 1 : n_in;
      for (int k = 0; k < n; k++)
        bq.push_back('{d: mknown[(a + k) % 1024] ? mmem[(a + k) % 1024] : 'x,
                       s: s, last: (k == n - 1)});
    end
    if (w && !r && rdy) begin
      mmem[a] = wd; mknown[a] = 1; e_done = 1;
    end
    if ((r || w) && !rdy) e_drop = 1;
    if (r && w) e_conf = 1;
    e_busy = (bq.size() != 0);
  endtask

  // Called at a negedge: drive, advance model, cross the edge, check at negedge.
  task automatic step(input bit r, input bit w, input int a, input int n,
                      input int s, input logic [VB-1:0] wd, input bit rn);
    rd = r; wr = w; addr = AW'(a); len = NV'(n); sdst = NS'(s); wdata = wd; rst_n = rn;
    model(r, w, a, n, NS'(s), wd, rn);
    @(posedge clk);
    @(negedge clk);
    chk("srf_wr_en", VB'(en), VB'(e_en));
    chk("busy", VB'(bsy), VB'(e_busy));
    chk("op_done", VB'(done), VB'(e_done));
    chk("cmd_dropped", VB'(drop), VB'(e_drop));
    chk("cmd_conflict", VB'(conf), VB'(e_conf));
    if (e_ds) begin
      chk("srf_wr_stream", VB'(ostrm), VB'(e_strm));
      if (e_known) chk("srf_wr_data", odata, e_data);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, '0, 1);
  endtask

  function automatic logic [VB-1:0] tagvec(input int base);
    logic [T-1:0][W-1:0] v;
    for (int i = 0; i < T; i++) v[i] = W'(base + i);
    return v;
  endfunction

  function automatic logic [VB-1:0] rndvec();
    logic [T-1:0][W-1:0] v;
    for (int i = 0; i < T; i++) v[i] = W'($urandom);
    return v;
  endfunction

  logic [T-1:0][W-1:0] exp_v;

  initial begin
    for (int i = 0; i < 1024; i++) mknown[i] = 0;
    rd = 0; wr = 0; addr = '0; len = '0; sdst = '0; wdata = '0; rst_n = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, 0, '0, 0);

    // single write then read
    step(0, 1, 5, 0, 0, tagvec(16'h100), 1);
    step(1, 0, 5, 1, 3, '0, 1);
    exp_v = tagvec(16'h100);
    chk("t1_busy_1cyc", VB'(bsy), VB'(1));
    step(0, 0, 0, 0, 0, '0, 1);
    chk("t1_lane19", VB'(odata[19]), VB'(exp_v[19]));
    chk("t1_stream", VB'(ostrm), VB'(3));
    chk("t1_busy_off", VB'(bsy), VB'(0));
    idle(2);

    // burst with wrap across 1023 -> 0
    step(0, 1, 1022, 0, 0, tagvec(16'hA0), 1);
    step(0, 1, 1023, 0, 0, tagvec(16'hA1), 1);
    step(0, 1, 0,    0, 0, tagvec(16'hA2), 1);
    step(0, 1, 1,    0, 0, tagvec(16'hA3), 1);
    step(1, 0, 1022, 4, 9, '0, 1);
    idle(5);

    // length zero
    step(0, 1, 7, 0, 0, tagvec(16'h700), 1);
    step(1, 0, 7, 0, 2, '0, 1);
    idle(3);

    // drop during burst, then conflict in idle
    step(0, 1, 40, 0, 0, tagvec(16'h4000), 1);
    step(1, 0, 100, 8, 4, '0, 1);
    idle(2);
    step(0, 1, 40, 0, 0, tagvec(16'hDEAD), 1);
    chk("drop_set", VB'(drop), VB'(1));
    idle(8);
    step(1, 1, 40, 1, 1, tagvec(16'hBEEF), 1);
    chk("conf_set", VB'(conf), VB'(1));
    step(1, 0, 40, 1, 6, '0, 1);
    idle(2);

    // back-to-back bursts; reset first clears sticky flags
    step(0, 0, 0, 0, 0, '0, 0);
    step(1, 0, 1022, 2, 5, '0, 1);
    idle(1);
    step(1, 0, 0, 2, 7, '0, 1);
    idle(3);
    chk("b2b_no_drop", VB'(drop), VB'(0));

    // reset mid-burst, SRAM retained
    step(1, 0, 1020, 10, 8, '0, 1);
    idle(4);
    step(0, 0, 0, 0, 0, '0, 0);
    chk("rst_en", VB'(en), VB'(0));
    step(1, 0, 1020, 10, 8, '0, 1);
    idle(12);

    // fill SRAM so every random read has a defined value
    for (int i = 0; i < 1024; i++) if (!mknown[i]) step(0, 1, i, 0, 0, rndvec(), 1);

    for (int c = 0; c < 3000; c++) begin
      int p;
      p = $urandom_range(0, 99);
      if (p < 15)      step(1, 0, $urandom_range(0, 1023), $urandom_range(0, 31), $urandom_range(0, 31), '0, 1);
      else if (p < 30) step(0, 1, $urandom_range(0, 1023), 0, 0, rndvec(), 1);
      else if (p < 33) step(1, 1, $urandom_range(0, 1023), $urandom_range(0, 31), 1, rndvec(), 1);
      else if (p < 35) step(0, 0, 0, 0, 0, '0, 0);
      else             idle(1);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
